uart_rcv: RTL and testbench
===========================

UART_RCV -- requirements
Module: uart_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per bit (50 MHz / 19200 baud).
REQ-002 clk  input  1  system clock; sole clock, all flops rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 RX  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-005 clr_rdy  input  1  consumer acknowledge, clears rdy.
REQ-006 rx_data  output  8  last received byte.
REQ-007 rdy  output  1  byte valid; held until cleared.
REQ-008 frm_err  output  1  stop bit sampled low on last frame.

Function
REQ-009 RX SHALL pass through a two-flop synchronizer, both stages preset to 1; all logic uses the synchronized value only.
REQ-010 FSM SHALL have two states: IDLE and RECEIVING.
REQ-011 IDLE -> RECEIVING on synchronized RX == 0. That cycle: load baud_cnt = BAUD_DIV/2 (1302), clear bit_cnt, clear rdy and frm_err.
REQ-012 In RECEIVING, baud_cnt SHALL decrement each clock. shift SHALL be asserted when baud_cnt == 0.
REQ-013 On shift: sample synchronized RX into MSB of a 9-bit shift register, shift right, reload baud_cnt = BAUD_DIV, increment bit_cnt.
REQ-014 The first sample is the mid-start-bit check. If it reads 1 (glitch), the FSM SHALL return to IDLE with no rdy and no data change.
REQ-015 After the 10th shift (start, 8 data, stop), the FSM SHALL go to IDLE, and the next cycle SHALL set rdy.
REQ-016 On frame completion, rx_data SHALL equal shift_reg[7:0], i.e. data bit 0 = first bit after start. The stop sample SHALL land in shift_reg[8].
REQ-017 Latency: rdy rises 1302 + 9*2604 + 2 clocks (±2) after start detection.
REQ-018 clr_rdy SHALL clear rdy the next cycle. Simultaneous set and clear: set wins.
REQ-019 A new start while rdy is still 1 SHALL clear rdy. The new byte overwrites rx_data; no overrun flag.
REQ-020 clr_rdy in RECEIVING SHALL NOT disturb reception.
REQ-021 bit_cnt is 4 bits and baud_cnt is 12 bits; neither SHALL wrap in normal operation.

Reset
REQ-022 On rst: state IDLE, rdy 0, frm_err 0, rx_data 0x00, shift register all ones, baud_cnt BAUD_DIV, bit_cnt 0, synchronizer 1.
REQ-023 rst mid-frame SHALL abort the frame with no rdy. Reception resumes on the next falling edge after rst deasserts.

Configuration
REQ-024 Macro UART_RCV_FRAMING_CHK_EN defined: frm_err SHALL be set together with rdy when the stop sample is 0, and cleared by clr_rdy or the next start.
REQ-025 Macro undefined: frm_err port SHALL remain and be tied 0; no framing logic is synthesized. rdy behaviour is unchanged.

Structure
REQ-026 Package uart_pkg SHALL hold the BAUD_DIV default, the half-bit constant, and the rx state enum (IDLE, RECEIVING).
REQ-027 The synchronizer SHALL be a separate sub-module, uart_rx_sync (2-flop, preset-high, synchronous reset).
REQ-028 Everything else (FSM, counters, shift register, flags) SHALL be in uart_rcv.

Verification
REQ-029 Send 0xA5 with valid stop bit -> rdy = 1 within REQ-017 window, rx_data = 0xA5, frm_err = 0.
REQ-030 Send 0x3C, no clr_rdy, then send 0xC3 -> rdy drops at second start, rx_data = 0xC3 at end; pulse clr_rdy -> rdy = 0 next cycle.
REQ-031 RX low for 500 clocks, then high -> FSM back in IDLE after the first sample, rdy stays 0, rx_data unchanged.
REQ-032 Send 0xFF with stop bit forced 0 -> with macro: rdy = 1, frm_err = 1. Without macro: rdy = 1, frm_err = 0.
REQ-033 Assert rst for 1 clock mid-data (bit 4), then send 0x5A -> no rdy for the aborted frame, rx_data = 0x5A, rdy = 1.
REQ-034 Assert clr_rdy on the same cycle rdy is set -> rdy = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receiver.
// Optional feature macro: UART_RCV_FRAMING_CHK_EN (stop-bit framing check).
package uart_pkg;

  // 50 MHz system clock / 19200 baud
  localparam int BAUD_DIV_DEFAULT = 2604;
  // Half a bit period: the first sample lands in the middle of the start bit
  localparam int HALF_BIT_DEFAULT = BAUD_DIV_DEFAULT / 2;

  localparam int BAUD_W     = 12;
  localparam int BIT_W      = 4;
  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  typedef enum logic {
    IDLE      = 1'b0,
    RECEIVING = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_rcv_if.sv
// Consumer-side bundle of the UART receiver.
// Handshake: rdy rises when a byte lands in rx_data and stays high until the
// consumer pulses clr_rdy (cleared on the following clock) or a new start bit
// arrives; if rdy is being set on the same clock clr_rdy is seen, rdy stays set.
interface uart_rcv_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  modport master (
    output RX,
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frm_err
  );

  modport slave (
    input  RX,
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frm_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; both stages come out
// of reset high so an idle line never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next-state: plain two-stage shift
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  // registers preset high on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rcv.sv
// 8N1 LSB-first UART receiver with a rdy/clr_rdy consumer handshake.
// Optional feature macro: UART_RCV_FRAMING_CHK_EN -- when defined, frm_err
// reports a stop bit sampled low; otherwise frm_err is tied low.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  uart_rcv_if.slave bus,
  output rx_state_e state_dbg
);

  localparam logic [BAUD_W-1:0] BAUD_RESET  = BAUD_W'(BAUD_DIV);
  localparam logic [BAUD_W-1:0] HALF_LOAD   = BAUD_W'(BAUD_DIV / 2);
  // Counting down to zero inclusive, so reloading DIV-1 gives DIV clocks per bit
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(FRAME_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.RX),
    .sync_out (rx_s)
  );

  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]        shift_reg_q, shift_reg_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic              rx_prev_q, rx_prev_d;
  logic              start;
  logic              shift;

  // FSM, bit timing, shift register and the rdy flag
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    done_d      = 1'b0;
    rx_prev_d   = rx_s;
    // A start needs a high-to-low transition so a line still low after an
    // abort or a bad stop bit is not mistaken for a new frame
    start = (state_q == IDLE) && rx_prev_q && !rx_s;
    shift = (state_q == RECEIVING) && (baud_cnt_q == '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RECEIVING;
          baud_cnt_d = HALF_LOAD;
          bit_cnt_d  = '0;
        end
      end
      RECEIVING: begin
        if (shift) begin
          shift_reg_d = {rx_s, shift_reg_q[8:1]};
          baud_cnt_d  = BAUD_RELOAD;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          if ((bit_cnt_q == '0) && rx_s) begin
            // start bit gone by mid-bit: a glitch, drop it silently
            state_d = IDLE;
          end else if (bit_cnt_q == LAST_BIT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
    endcase

    // clear sources first so a completing frame (set) has the last word
    if (bus.clr_rdy) rdy_d = 1'b0;
    if (start)       rdy_d = 1'b0;
    if (done_q) begin
      rdy_d     = 1'b1;
      rx_data_d = shift_reg_q[7:0];
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= BAUD_RESET;
      bit_cnt_q   <= '0;
      shift_reg_q <= '1;
      rx_data_q   <= '0;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
      rx_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      done_q      <= done_d;
      rx_prev_q   <= rx_prev_d;
    end
  end

`ifdef UART_RCV_FRAMING_CHK_EN
  logic frm_err_q, frm_err_d;

  // framing flag follows rdy: set from the stop sample, cleared with rdy
  always_comb begin
    frm_err_d = frm_err_q;
    if (bus.clr_rdy || start) frm_err_d = 1'b0;
    if (done_q)               frm_err_d = ~shift_reg_q[8];
  end

  // framing flag register
  always_ff @(posedge clk) begin
    if (rst) frm_err_q <= 1'b0;
    else     frm_err_q <= frm_err_d;
  end

  assign bus.frm_err = frm_err_q;
`else
  assign bus.frm_err = 1'b0;
`endif

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Directed bench for uart_rcv with a shortened bit period.
// Expected frames go into exp_q; a monitor pops one on every rdy rise.
module tb_uart_rcv;
  import uart_pkg::*;

  localparam int B    = 16;  // clocks per bit in this bench
  localparam int HALF = 8;   // B/2
  // start detect to rdy: 8 + 9*16 + 2 = 154 clocks
  localparam int LAT_NOM = 154;

`ifdef UART_RCV_FRAMING_CHK_EN
  localparam logic FERR_EXP = 1'b1;
`else
  localparam logic FERR_EXP = 1'b0;
`endif

  logic      clk;
  logic      rst;
  rx_state_e state_dbg;
  uart_rcv_if bus ();

  uart_rcv #(.BAUD_DIV(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];  // {frm_err, rx_data}
  int n_vec = 0;
  int n_err = 0;
  int t_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every rising rdy must match the oldest expected frame
  initial begin
    logic       rdy_prev;
    logic [8:0] e;
    int         lat;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rdy && !rdy_prev) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rdy: got rdy=1 data=0x%0h expected no frame", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", 32'(bus.rx_data), 32'(e[7:0]));
          check("frame_frm_err", 32'(bus.frm_err), 32'(e[8]));
          lat = cyc - t_start - 3;  // 3 clocks of synchronizer + start detect
          n_vec++;
          if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin
            n_err++;
            $display("FAIL latency: got %0d expected %0d +/-2", lat, LAT_NOM);
          end
        end
      end
      rdy_prev = bus.rdy;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive(input logic v, input int n);
    bus.RX = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok,
                           input bit chk_drop, input bit clr_mid);
    bus.RX  = 1'b0;
    t_start = cyc;
    repeat (B) @(negedge clk);
    if (chk_drop) check("rdy_drop_on_start", 32'(bus.rdy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (clr_mid && i == 3) begin
        bus.RX = d[i];
        repeat (HALF) @(negedge clk);
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        repeat (B - HALF - 1) @(negedge clk);
      end else begin
        drive(d[i], B);
      end
    end
    if (stop_ok) begin
      drive(1'b1, B);
    end else begin
      drive(1'b0, B);
      drive(1'b1, B);
    end
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_rdy", 32'(bus.rdy), 32'd0);
    check("reset_frm_err", 32'(bus.frm_err), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    drive(1'b1, 4);

    // clean 0xA5, then acknowledge
    exp_q.push_back({1'b0, 8'hA5});
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
    drive(1'b1, B);
    check("a5_rdy_held", 32'(bus.rdy), 32'd1);
    pulse_clr();
    check("a5_rdy_cleared", 32'(bus.rdy), 32'd0);

    // 0x3C with clr_rdy mid-frame, left unacknowledged, then 0xC3
    exp_q.push_back({1'b0, 8'h3C});
    send_byte(8'h3C, 1'b1, 1'b0, 1'b1);
    drive(1'b1, B);
    check("3c_rdy_held", 32'(bus.rdy), 32'd1);
    exp_q.push_back({1'b0, 8'hC3});
    send_byte(8'hC3, 1'b1, 1'b1, 1'b0);
    drive(1'b1, B);
    check("c3_data", 32'(bus.rx_data), 32'hC3);
    pulse_clr();
    check("c3_rdy_cleared", 32'(bus.rdy), 32'd0);

    // short low glitch: shorter than half a bit
    bus.RX = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_receiving", 32'(state_dbg), 32'(RECEIVING));
    drive(1'b1, B);
    check("glitch_idle", 32'(state_dbg), 32'(IDLE));
    check("glitch_rdy", 32'(bus.rdy), 32'd0);
    check("glitch_data", 32'(bus.rx_data), 32'hC3);

    // 0xFF with the stop bit low
    exp_q.push_back({FERR_EXP, 8'hFF});
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    check("ff_rdy", 32'(bus.rdy), 32'd1);
    check("ff_frm_err", 32'(bus.frm_err), 32'(FERR_EXP));
    pulse_clr();
    check("ff_rdy_cleared", 32'(bus.rdy), 32'd0);
    check("ff_frm_err_cleared", 32'(bus.frm_err), 32'd0);
    drive(1'b1, B);

    // 0xF0 aborted by a one-clock reset in the middle of bit 4
    bus.RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) drive(1'b0, B);
    drive(1'b1, HALF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    check("abort_rx_data", 32'(bus.rx_data), 32'h00);
    drive(1'b1, B - HALF - 1 + 3 * B + B + 2 * B);
    check("abort_no_rdy", 32'(bus.rdy), 32'd0);
    exp_q.push_back({1'b0, 8'h5A});
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
    check("5a_rdy", 32'(bus.rdy), 32'd1);
    check("5a_data", 32'(bus.rx_data), 32'h5A);
    pulse_clr();
    drive(1'b1, B);

    // clr_rdy on the very clock rdy is set: set wins
    exp_q.push_back({1'b0, 8'h96});
    fork
      send_byte(8'h96, 1'b1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        for (int i = 0; i < 400 && cyc != t_start + 3 + LAT_NOM - 1; i++) @(negedge clk);
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        check("set_wins_rdy", 32'(bus.rdy), 32'd1);
      end
    join
    drive(1'b1, B);
    check("set_wins_data", 32'(bus.rx_data), 32'h96);

    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
